// File: rtl/tmr_lane_monitor.sv
// Health monitor downstream of a 3-way majority voter: tracks per-lane mismatch runs
// and saturating error counts, cross-checks the voter and offers a clear handshake.

module tmr_lane_track #(
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_valid,
  input  logic             i_mis,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_fault,
  output logic             o_fault_next
);
  typedef enum logic [1:0] {L_OK, L_SUSPECT, L_FAULTY} lane_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [7:0]       THRESH8 = 8'(FAULT_THRESH);

  lane_state_t      r_state, w_state_next;
  logic [7:0]       r_run, w_run_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_fault;

  always_comb begin
    w_state_next = r_state;
    w_run_next   = r_run;
    w_cnt_next   = r_cnt;
    if (i_clr) begin
      w_state_next = L_OK;
      w_run_next   = 8'd0;
      w_cnt_next   = '0;
    end else if (i_valid) begin
      if (i_mis && r_cnt != CNT_MAX) w_cnt_next = r_cnt + CNT_W'(1);
      case (r_state)
        L_OK: begin
          if (i_mis) begin
            w_run_next   = 8'd1;
            w_state_next = (FAULT_THRESH == 1) ? L_FAULTY : L_SUSPECT;
          end
        end
        L_SUSPECT: begin
          if (i_mis) begin
            w_run_next = r_run + 8'd1;
            if (r_run + 8'd1 >= THRESH8) w_state_next = L_FAULTY;
          end else begin
            w_run_next   = 8'd0;
            w_state_next = L_OK;
          end
        end
        // Sticky: only a clear or reset leaves FAULTY.
        L_FAULTY: w_state_next = L_FAULTY;
        default:  w_state_next = L_OK;
      endcase
    end
  end

  assign o_fault_next = (w_state_next == L_FAULTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= L_OK;
      r_run   <= 8'd0;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_run   <= w_run_next;
      r_cnt   <= w_cnt_next;
      r_fault <= o_fault_next;
    end
  end

  assign o_cnt   = r_cnt;
  assign o_fault = r_fault;
endmodule

module tmr_lane_monitor #(
  parameter int WIDTH        = 1,
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] lane_a,
  input  logic [WIDTH-1:0] lane_b,
  input  logic [WIDTH-1:0] lane_c,
  input  logic [WIDTH-1:0] voted,
  input  logic             clr_req,
  output logic             clr_ack,
  output logic [2:0]       lane_fault,
  output logic             degraded,
  output logic             voter_err,
  output logic [CNT_W-1:0] err_cnt_a,
  output logic [CNT_W-1:0] err_cnt_b,
  output logic [CNT_W-1:0] err_cnt_c
);
  typedef enum logic [1:0] {C_IDLE, C_ACK, C_WAIT} clr_state_t;

  clr_state_t       r_cstate;
  logic             r_clr_ack;
  logic             r_voter_err;
  logic             r_degraded;
  logic             w_clr;
  logic [WIDTH-1:0] w_lane [3];
  logic [WIDTH-1:0] w_ref;
  logic [2:0]       w_mis;
  logic [2:0]       w_fault;
  logic [2:0]       w_fault_next;
  logic [CNT_W-1:0] w_cnt [3];

  // A clear fires only from IDLE, and it overrides any sample taken in the same cycle.
  assign w_clr = (r_cstate == C_IDLE) && clr_req;

  assign w_lane[0] = lane_a;
  assign w_lane[1] = lane_b;
  assign w_lane[2] = lane_c;
  assign w_ref     = (lane_a & lane_b) | (lane_b & lane_c) | (lane_c & lane_a);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      assign w_mis[gi] = valid_in && (w_lane[gi] != voted);
      tmr_lane_track #(
        .FAULT_THRESH(FAULT_THRESH),
        .CNT_W       (CNT_W)
      ) u_track (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_clr),
        .i_valid     (valid_in),
        .i_mis       (w_mis[gi]),
        .o_cnt       (w_cnt[gi]),
        .o_fault     (w_fault[gi]),
        .o_fault_next(w_fault_next[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cstate    <= C_IDLE;
      r_clr_ack   <= 1'b0;
      r_voter_err <= 1'b0;
      r_degraded  <= 1'b0;
    end else begin
      case (r_cstate)
        C_IDLE: begin
          if (clr_req) begin
            r_clr_ack <= 1'b1;
            r_cstate  <= C_ACK;
          end
        end
        C_ACK: begin
          r_clr_ack <= 1'b0;
          r_cstate  <= C_WAIT;
        end
        C_WAIT: begin
          if (!clr_req) r_cstate <= C_IDLE;
        end
        default: begin
          r_clr_ack <= 1'b0;
          r_cstate  <= C_IDLE;
        end
      endcase

      if (w_clr)                            r_voter_err <= 1'b0;
      else if (valid_in && w_ref != voted)  r_voter_err <= 1'b1;

      r_degraded <= (w_fault_next[0] & w_fault_next[1]) |
                    (w_fault_next[1] & w_fault_next[2]) |
                    (w_fault_next[0] & w_fault_next[2]);
    end
  end

  assign clr_ack    = r_clr_ack;
  assign lane_fault = w_fault;
  assign degraded   = r_degraded;
  assign voter_err  = r_voter_err;
  assign err_cnt_a  = w_cnt[0];
  assign err_cnt_b  = w_cnt[1];
  assign err_cnt_c  = w_cnt[2];
endmodule

// File: doc/tmr_lane_monitor.md
Name: tmr_lane_monitor

Overview:
- Sits directly downstream of the 3-input majority voter.
- Each valid cycle it consumes the three redundant lanes and the voter output. It tracks per-lane disagreement with the voted value, declares a lane faulty after a run of consecutive mismatches, and cross-checks the voter itself.
- It feeds fault status and error counts to the system health logic. It does not alter the data path.

Parameters:
- WIDTH, 1: bit width of each lane and of the voted value.
- FAULT_THRESH, 4: consecutive mismatching valid samples needed to declare a lane faulty. Range 1..255.
- CNT_W, 16: width of the saturating total-error counters.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- valid_in  input  1  lane_a/b/c and voted are sampled this cycle
- lane_a  input  WIDTH  redundant copy A
- lane_b  input  WIDTH  redundant copy B
- lane_c  input  WIDTH  redundant copy C
- voted  input  WIDTH  voter output for the same cycle
- clr_req  input  1  level request to clear faults and counters
- clr_ack  output  1  one-cycle acknowledge of a clear
- lane_fault  output  3  sticky fault flags; bit0=A, bit1=B, bit2=C
- degraded  output  1  two or more lane_fault bits set
- voter_err  output  1  sticky; voted differed from the recomputed bitwise majority
- err_cnt_a  output  CNT_W  saturating mismatch count, lane A
- err_cnt_b  output  CNT_W  saturating mismatch count, lane B
- err_cnt_c  output  CNT_W  saturating mismatch count, lane C

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values: clr_ack=0, lane_fault=3'b000, degraded=0, voter_err=0, all err_cnt=0, all run counters=0, all lane FSMs in OK, clear FSM in IDLE.
- Mismatch definition: lane X mismatches when valid_in=1 and (lane_X != voted) on any bit.
- Voter check: ref = (a&b)|(b&c)|(c&a), bitwise. voter_err sets when valid_in=1 and ref != voted.
- Latency: a sample at edge N is reflected in outputs after edge N+1, i.e. visible in cycle N+1.
- valid_in=0: no state changes at all. Run counters hold and are not reset by gaps.
- err_cnt_X: increments by 1 per mismatching valid sample. Saturates at 2^CNT_W-1 and never wraps.
- Per-lane FSM, with an 8-bit run counter:
  - OK: on mismatch, run=1 and go to SUSPECT. If FAULT_THRESH=1, go straight to FAULTY instead.
  - SUSPECT: on mismatch, run+1. When run reaches FAULT_THRESH, go to FAULTY. On a matching valid sample, run=0 and return to OK.
  - FAULTY: sticky. Counting continues. Only a clear or rst leaves this state.
  - lane_fault[X]=1 exactly while the lane is in FAULTY.
- degraded: the registered value of popcount(next lane_fault)>=2. It updates on the same edge as lane_fault.
- Clear handshake FSM:
  - IDLE: if clr_req=1, then on that edge zero all err_cnt, run counters, lane_fault, voter_err and degraded, move all lanes to OK, set clr_ack=1 and go to ACK.
  - ACK: clr_ack=0 on the next edge. Go to WAIT.
  - WAIT: stay while clr_req=1 and issue no further clears. When clr_req=0, return to IDLE.
  - clr_ack is therefore exactly one cycle per rising request.
- Clear and sample in the same cycle: the clear wins. That cycle's sample is discarded and does not count.
- rst mid-handshake: return to IDLE with clr_ack=0. A still-high clr_req is treated as a new request on the first post-reset edge.
- Multi-lane mismatch in one cycle (possible for WIDTH>1): each lane is updated independently.

Test Plan:
- Reset, then 10 valid samples with a=b=c=voted=1: all outputs stay at 0 and err_cnt_* = 0.
- Lane B inverted for 4 consecutive valid samples (FAULT_THRESH=4): lane_fault=3'b010 after the 4th sample's edge, err_cnt_b=4, degraded=0.
- Lane A mismatches 3 times, then matches once, then mismatches 3 times: lane_fault[0] stays 0, err_cnt_a=6.
- Lanes A then C each driven faulty: degraded=1 on the same cycle lane_fault becomes 3'b101. Then pulse clr_req for 3 cycles: exactly one clr_ack pulse and all outputs return to 0.
- voted forced to 0 while a=b=c=1: voter_err=1 one cycle later, and all err_cnt_*=1. With CNT_W=4, 20 such samples leave all err_cnt_* at 15.
- clr_req asserted in the same cycle as a lane C mismatch: after the edge err_cnt_c=0 and lane C is in OK; rst asserted during WAIT forces clr_ack=0.
